// File: rtl/stream_mux_pkg.sv
// stream_mux shared types and legality limits.
// Mode encoding matches the 1-bit mode input.
package stream_mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  localparam int N_MAX = 16;
  localparam int W_MAX = 64;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotating-priority arbiter.
// Scan starts one past ptr, so ptr is the last winner.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [SW-1:0] idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = SW'((int'(ptr) + k) % N);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
        gnt[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-channel registered valid/ready stream mux, select or round-robin.
// Define STREAM_MUX_LAST_EN to build packet lock and forward in_last.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic [SW-1:0]  out_ch,
  input  logic           out_ready
);

  logic          load;
  logic          xfer;
  logic          xfer_last;
  logic          grant_valid;
  logic [SW-1:0] grant;
  logic [W-1:0]  gdata;
  logic          sel_ok;
  logic          locked;
  logic [SW-1:0] lock_ch;

  logic [N-1:0]  rr_gnt_unused;
  logic [SW-1:0] rr_idx;
  logic          rr_valid;

  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic          out_last_q;
  logic [SW-1:0] out_ch_q;
  logic [SW-1:0] ptr_q;

  rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt       (rr_gnt_unused),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_valid)
  );

  assign load   = !out_valid_q || out_ready;
  assign sel_ok = int'(sel) < N;

`ifdef STREAM_MUX_LAST_EN
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_e;

  lock_e         state_q, state_d;
  logic [SW-1:0] lock_ch_q, lock_ch_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= UNLOCKED;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      if (in_last[grant]) begin
        state_d = UNLOCKED;
      end else begin
        state_d   = LOCKED;
        lock_ch_d = grant;
      end
    end
  end

  assign locked    = (state_q == LOCKED);
  assign lock_ch   = lock_ch_q;
  assign xfer_last = in_last[grant];
`else
  logic unused_last;
  assign unused_last = ^in_last;
  assign locked      = 1'b0;
  assign lock_ch     = '0;
  assign xfer_last   = 1'b0;
`endif

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    unique case (1'b1)
      locked: begin
        grant       = lock_ch;
        grant_valid = in_valid[lock_ch];
      end
      (!locked && mode_e'(mode) == MODE_SEL): begin
        grant       = sel;
        grant_valid = sel_ok && in_valid[sel];
      end
      (!locked && mode_e'(mode) == MODE_RR): begin
        grant       = rr_idx;
        grant_valid = rr_valid;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready = '0;
    gdata    = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SW'(i)) begin
        gdata       = in_data[i*W +: W];
        in_ready[i] = rst_n && load && grant_valid;
      end
    end
  end

  assign xfer = |in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      ptr_q       <= SW'(N - 1);
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= gdata;
      out_last_q  <= xfer_last;
      out_ch_q    <= grant;
      ptr_q       <= grant;
    end else if (load) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule
